// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle RV32I main controller.
package mc_pkg;

  // FSM state codes
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_JALR     = 4'd11;
  localparam logic [3:0] S_LINK     = 4'd12;
  localparam logic [3:0] S_LUI      = 4'd13;
  localparam logic [3:0] S_TRAP     = 4'd14;

  // Opcodes
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // ALU operations
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  // Immediate formats
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Result mux
  localparam logic [1:0] RES_ALU_OUT    = 2'b00;
  localparam logic [1:0] RES_MEM        = 2'b01;
  localparam logic [1:0] RES_ALU_RESULT = 2'b10;
  localparam logic [1:0] RES_IMM        = 2'b11;

  // ALU operand muxes
  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_REG    = 2'b10;
  localparam logic [1:0] SRC_B_RD2    = 2'b00;
  localparam logic [1:0] SRC_B_IMM    = 2'b01;
  localparam logic [1:0] SRC_B_FOUR   = 2'b10;

  // Class of ALU operation requested by the FSM
  typedef enum logic [1:0] {
    AOP_ADD   = 2'b00,
    AOP_SUB   = 2'b01,
    AOP_FUNCT = 2'b10
  } alu_op_t;

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALU-op class plus funct fields to a concrete ALU operation.
module alu_decoder
  import mc_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic       op5,        // 1 for R-type, 0 for I-type ALU ops
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] alu_control
);

  // Decode operation; funct7b5 selects sub only for R-type, sra for both
  always_comb begin
    // NOTE: default first so every path assigns the output and no latch is inferred.
    alu_control = ALU_ADD;
    case (alu_op)
      AOP_ADD: alu_control = ALU_ADD;
      AOP_SUB: alu_control = ALU_SUB;
      default: begin
        case (funct3)
          3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Main control FSM of the multicycle RV32I core.
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       cout,
  input  logic       overflow,
  input  logic       sign,
  output logic [2:0] imm_src,
  output logic [3:0] alu_control,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       adr_src,
  output logic       ir_write,
  output logic       reg_write,
  output logic       pc_write,
  output logic       mem_write,
  output logic       illegal
);

  logic [3:0] state, next_state;
  alu_op_t    alu_op;
  logic       taken, branch_bad;
  logic       ir_en, reg_en, pc_en, mem_en, trap_flag;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (!reset) state <= S_FETCH;
    else        state <= next_state;
  end

  // Branch condition from the ALU flags of rs1 - rs2
  always_comb begin
    taken      = 1'b0;
    branch_bad = 1'b0;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = sign ^ overflow;
      3'b101:  taken = !(sign ^ overflow);
      3'b110:  taken = !cout;
      3'b111:  taken = cout;
      default: branch_bad = 1'b1;
    endcase
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_R:              next_state = S_EXECR;
          OP_I:              next_state = S_EXECI;
          OP_BRANCH:         next_state = S_BRANCH;
          OP_JAL:            next_state = S_JAL;
          OP_JALR:           next_state = S_JALR;
          OP_LUI:            next_state = S_LUI;
          OP_AUIPC:          next_state = S_ALUWB;
          default:           next_state = S_TRAP;
        endcase
      end
      S_MEMADR:   next_state = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  next_state = S_MEMWB;
      S_EXECR,
      S_EXECI,
      S_JAL:      next_state = S_ALUWB;
      S_BRANCH:   next_state = branch_bad ? S_TRAP : S_FETCH;
      S_JALR:     next_state = S_LINK;
      S_TRAP:     next_state = S_TRAP;
      default:    next_state = S_FETCH;
    endcase
  end

  // Per-state selects and raw enables
  always_comb begin
    result_src = RES_ALU_OUT;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RD2;
    adr_src    = 1'b0;
    alu_op     = AOP_ADD;
    ir_en      = 1'b0;
    reg_en     = 1'b0;
    pc_en      = 1'b0;
    mem_en     = 1'b0;
    trap_flag  = 1'b0;
    case (state)
      S_FETCH: begin
        ir_en = 1'b1; pc_en = 1'b1;
        alu_src_b = SRC_B_FOUR; result_src = RES_ALU_RESULT;
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLD_PC; alu_src_b = SRC_B_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRC_A_REG; alu_src_b = SRC_B_IMM;
      end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src = RES_MEM; reg_en = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1; mem_en = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRC_A_REG; alu_op = AOP_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = SRC_A_REG; alu_src_b = SRC_B_IMM; alu_op = AOP_FUNCT;
      end
      S_ALUWB:    reg_en = 1'b1;
      S_BRANCH: begin
        alu_src_a = SRC_A_REG; alu_op = AOP_SUB; pc_en = taken;
      end
      S_JAL: begin
        pc_en = 1'b1; alu_src_a = SRC_A_OLD_PC; alu_src_b = SRC_B_FOUR;
      end
      S_JALR: begin
        alu_src_a = SRC_A_REG; alu_src_b = SRC_B_IMM;
        result_src = RES_ALU_RESULT; pc_en = 1'b1;
      end
      S_LINK: begin
        alu_src_a = SRC_A_OLD_PC; alu_src_b = SRC_B_FOUR;
        result_src = RES_ALU_RESULT; reg_en = 1'b1;
      end
      S_LUI: begin
        result_src = RES_IMM; reg_en = 1'b1;
      end
      S_TRAP:     trap_flag = 1'b1;
      default:    ;
    endcase
  end

  // Immediate format follows the opcode in every state
  always_comb begin
    case (op)
      OP_STORE:          imm_src = IMM_S;
      OP_BRANCH:         imm_src = IMM_B;
      OP_JAL:            imm_src = IMM_J;
      OP_LUI, OP_AUIPC:  imm_src = IMM_U;
      default:           imm_src = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .op5         (op[5]),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_control (alu_control)
  );

  // NOTE: enables are gated by reset so the FETCH state held during reset cannot write anything.
  assign ir_write  = ir_en     & reset;
  assign reg_write = reg_en    & reset;
  assign pc_write  = pc_en     & reset;
  assign mem_write = mem_en    & reset;
  assign illegal   = trap_flag & reset;

endmodule

// File: doc/mc_controller.md
# mc_controller

Main control FSM for the multicycle RV32I core. It sits directly upstream of the datapath and drives every datapath select and enable from the latched instruction fields and the ALU flags. It also produces the external memory write strobe and an illegal-instruction flag. One instruction completes every 3–5 cycles, and no two instructions overlap.

## Interface
- No parameters. Encodings are fixed in the shared package.
- `clk` in 1 — rising-edge clock.
- `reset` in 1 — asynchronous, active-low reset.
- `op` in 7 — `instr[6:0]` from the datapath IR.
- `funct3` in 3 — `instr[14:12]`.
- `funct7b5` in 1 — `instr[30]`.
- `zero`, `cout`, `overflow`, `sign` in 1 each — combinational ALU flags from the datapath.
- `imm_src` out 3 — immediate format: I=000, S=001, B=010, J=011, U=100.
- `alu_control` out 4 — ALU operation: add 0000, sub 0001, and 0010, or 0011, xor 0100, sll 0101, srl 0110, sra 0111, slt 1000, sltu 1001.
- `result_src` out 2 — result mux: 00 `alu_out`, 01 mem data, 10 `alu_result`, 11 `imm_ext`.
- `alu_src_a` out 2 — ALU A mux: 00 pc, 01 old_pc, 10 A.
- `alu_src_b` out 2 — ALU B mux: 00 rd2, 01 imm, 10 constant 4.
- `adr_src` out 1 — memory address: 0 pc, 1 result.
- `ir_write`, `reg_write`, `pc_write`, `mem_write` out 1 each — enables.
- `illegal` out 1 — high while the FSM is in TRAP.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, LINK, LUI, TRAP.
- Per-state controls (any control not listed = 0):
  - FETCH: adr_src=0, ir_write=1, a=00, b=10, add, result_src=10, pc_write=1 → DECODE.
  - DECODE: a=01, b=01, add (branch target or auipc sum into `alu_out`). Next state by op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR
    - 0110111 → LUI
    - 0010111 → ALUWB (auipc)
    - anything else → TRAP
  - MEMADR: a=10, b=01, add → MEMREAD for a load, MEMWRITE for a store.
  - MEMREAD: result_src=00, adr_src=1 → MEMWB.
  - MEMWB: result_src=01, reg_write=1 → FETCH.
  - MEMWRITE: result_src=00, adr_src=1, mem_write=1 → FETCH.
  - EXECR: a=10, b=00, ALU op from funct3/funct7b5 → ALUWB.
  - EXECI: a=10, b=01, ALU op from funct3; funct7b5 is honoured only for shifts (funct3=101) → ALUWB.
  - ALUWB: result_src=00, reg_write=1 → FETCH.
  - BRANCH: a=10, b=00, sub, result_src=00, pc_write=taken → FETCH. taken by funct3:
    - 000 beq: zero
    - 001 bne: !zero
    - 100 blt: sign^overflow
    - 101 bge: !(sign^overflow)
    - 110 bltu: !cout
    - 111 bgeu: cout
    - 010 or 011: TRAP instead of FETCH
  - JAL: result_src=00, pc_write=1, a=01, b=10, add (old_pc+4 into `alu_out`) → ALUWB.
  - JALR: a=10, b=01, add, result_src=10, pc_write=1 → LINK.
  - LINK: a=01, b=10, add, result_src=10, reg_write=1 → FETCH. Correct when rd==rs1, because A was latched before the write.
  - LUI: result_src=11, reg_write=1 → FETCH.
  - TRAP: all enables 0, illegal=1. Held until reset.
- `imm_src` is decoded combinationally from `op` in every state:
  - load, jalr, I-ALU → I
  - store → S
  - branch → B
  - jal → J
  - lui, auipc → U
  - other → I
- R-type ALU op: funct3 000 with funct7b5=1 → sub; 101 with funct7b5 → sra/srl; 010 → slt; 011 → sltu.

## Timing
- Moore outputs come from the state register, except `imm_src` (from op), `alu_control` in EXECR/EXECI (from funct) and `pc_write` in BRANCH (from flags). These are combinational from inputs that are stable inside the state.
- Cycles per instruction, FETCH included: load 5; store 4; R/I 4; branch 3; jal 4; jalr 4; lui 3; auipc 3.
- While `reset`=0: state=FETCH, `ir_write`/`reg_write`/`pc_write`/`mem_write`/`illegal` forced 0. Selects hold FETCH values (adr_src=0, a=00, b=10, result_src=10, alu_control=0000).
- First FETCH enables assert in the first cycle after reset release.
- Reset mid-instruction returns the FSM to FETCH immediately; partial register or memory writes never occur after reset assertion.
- `reg_write` and `mem_write` are never high in the same cycle. `pc_write` and `reg_write` are both high only in the LINK/JAL flows defined above (JALR→LINK keeps them in separate cycles).

## Structure
- Shared package `mc_pkg`:
  - state enum
  - opcode localparams
  - alu_control, imm_src, result_src, alu_src_a/b encodings
- Sub-module `alu_decoder`: combinational op/funct3/funct7b5/ALU-op-class → alu_control.
- Branch-condition evaluation stays in the top level.

## Test plan
- Reset low for 3 cycles, then release → during reset all enables 0; first cycle after release: ir_write=1, pc_write=1, adr_src=0.
- `add` (op 0110011, funct3 000, funct7b5 0) → FETCH, DECODE, EXECR (alu_control=0000), ALUWB (reg_write=1, result_src=00); 4 cycles.
- `lw` → MEMREAD has adr_src=1; MEMWB has result_src=01, reg_write=1; `sw` asserts mem_write=1 for exactly one cycle.
- `beq` with zero=1 → pc_write=1 in BRANCH; zero=0 → pc_write=0. `bltu` with cout=0 → taken; `bge` with sign=1, overflow=1 → taken.
- `jalr` → JALR cycle: pc_write=1, result_src=10; LINK cycle: reg_write=1, a=01, b=10.
- op 0000000 → TRAP, illegal=1 held for 10 cycles with all enables 0; reset pulse → FETCH.
